// File: rtl/aria_pkg.sv
// Shared encodings for the ARIA key-load path: key-buffer ops and FSM states.
package aria_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned ST_W   = 6;
    localparam int unsigned TO_W   = 8;

    // cmd_op / kb_op encodings
    localparam logic [OP_W-1:0] KOP_128 = 2'd0;
    localparam logic [OP_W-1:0] KOP_256 = 2'd1;
    localparam logic [OP_W-1:0] KOP_SW  = 2'd2;
    localparam logic [OP_W-1:0] KOP_CW  = 2'd3;

    // One-hot FSM state encodings
    localparam logic [ST_W-1:0] ST_IDLE   = 6'b000001;
    localparam logic [ST_W-1:0] ST_ISSUE  = 6'b000010;
    localparam logic [ST_W-1:0] ST_FILL   = 6'b000100;
    localparam logic [ST_W-1:0] ST_PUSH   = 6'b001000;
    localparam logic [ST_W-1:0] ST_SETTLE = 6'b010000;
    localparam logic [ST_W-1:0] ST_DONE   = 6'b100000;

    // Bit positions of the one-hot state vector
    localparam int unsigned S_IDLE  = 0;
    localparam int unsigned S_ISSUE = 1;
    localparam int unsigned S_FILL  = 2;
    localparam int unsigned S_PUSH  = 3;

    // Ops that need host key words streamed through the assembler
    function automatic logic op_needs_words(input logic [OP_W-1:0] op);
        return (op == KOP_128) || (op == KOP_256);
    endfunction

endpackage

// File: rtl/aria_key_word_pack.sv
// 32->128 key word assembler: first word lands at [127:96], fourth at [31:0].
module aria_key_word_pack
    import aria_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [WORD_W-1:0] word,
    output logic [KEY_W-1:0]  data,
    output logic              full_c
);

    logic [1:0] cnt;

    // Shift register and word counter; counter wraps after the fourth word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else if (clr) begin
            data <= '0;
            cnt  <= '0;
        end else if (push) begin
            data <= {data[KEY_W-WORD_W-1:0], word};
            cnt  <= cnt + 2'd1;
        end
    end

    // High in the cycle the fourth word of a beat is accepted
    assign full_c = push && (cnt == 2'd3);

endmodule

// File: rtl/aria_key_load_ctrl.sv
// Key-load controller: takes a load command, gathers host key words into
// 128-bit beats and hands them to the ARIA key buffer with timeout/abort.
module aria_key_load_ctrl
    import aria_pkg::*;
#(
    parameter int unsigned KB_TO = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_core,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic              cmd_abort,
    input  logic              wr_vld,
    output logic              wr_rdy,
    input  logic [WORD_W-1:0] wr_data,
    output logic [OP_W-1:0]   kb_op,
    output logic              kb_en,
    output logic              kb_clr,
    output logic [KEY_W-1:0]  wb_d,
    output logic              kb_d_vld,
    input  logic              kb_d_rdy,
    output logic              busy,
    output logic              key_vld,
    output logic              err
);

    logic [ST_W-1:0] state, state_nxt;
    logic [OP_W-1:0] kb_op_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            beat, beat_nxt;
    logic            key_vld_nxt, err_nxt, kb_clr_nxt;
    logic            pack_clr_c, pack_push_c, pack_full_c;

    // Handshake/strobe outputs are state flop bits, so they are glitch-free
    assign cmd_rdy  = state[S_IDLE];
    assign busy     = ~state[S_IDLE];
    assign kb_en    = state[S_ISSUE];
    assign wr_rdy   = state[S_FILL];
    assign kb_d_vld = state[S_PUSH];

    assign pack_push_c = wr_vld && state[S_FILL];

    aria_key_word_pack u_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (pack_clr_c),
        .push   (pack_push_c),
        .word   (wr_data),
        .data   (wb_d),
        .full_c (pack_full_c)
    );

    // State and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            kb_op   <= KOP_128;
            to_cnt  <= '0;
            beat    <= 1'b0;
            key_vld <= 1'b0;
            err     <= 1'b0;
            kb_clr  <= 1'b0;
        end else begin
            state   <= state_nxt;
            kb_op   <= kb_op_nxt;
            to_cnt  <= to_cnt_nxt;
            beat    <= beat_nxt;
            key_vld <= key_vld_nxt;
            err     <= err_nxt;
            kb_clr  <= kb_clr_nxt;
        end
    end

    // Next state: clr_core > cmd_abort > timeout > normal progress
    always_comb begin
        state_nxt   = state;
        kb_op_nxt   = kb_op;
        to_cnt_nxt  = to_cnt;
        beat_nxt    = beat;
        key_vld_nxt = key_vld;
        err_nxt     = err;
        kb_clr_nxt  = 1'b0;
        pack_clr_c  = 1'b0;

        if (clr_core) begin
            state_nxt   = ST_IDLE;
            to_cnt_nxt  = '0;
            beat_nxt    = 1'b0;
            key_vld_nxt = 1'b0;
            err_nxt     = 1'b0;
            pack_clr_c  = 1'b1;
        end else if (cmd_abort && !state[S_IDLE]) begin
            state_nxt   = ST_IDLE;
            to_cnt_nxt  = '0;
            beat_nxt    = 1'b0;
            key_vld_nxt = 1'b0;
            kb_clr_nxt  = 1'b1;
            pack_clr_c  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        kb_op_nxt   = cmd_op;
                        key_vld_nxt = 1'b0;
                        err_nxt     = 1'b0;
                        beat_nxt    = 1'b0;
                        state_nxt   = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_nxt = op_needs_words(kb_op) ? ST_FILL : ST_SETTLE;
                end
                ST_FILL: begin
                    if (pack_full_c) begin
                        to_cnt_nxt = '0;
                        state_nxt  = ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (kb_d_rdy) begin
                        if ((kb_op == KOP_256) && !beat) begin
                            beat_nxt  = 1'b1;
                            state_nxt = ST_FILL;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end else if (to_cnt == TO_W'(KB_TO - 1)) begin
                        err_nxt     = 1'b1;
                        kb_clr_nxt  = 1'b1;
                        key_vld_nxt = 1'b0;
                        to_cnt_nxt  = '0;
                        beat_nxt    = 1'b0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        to_cnt_nxt = to_cnt + TO_W'(1);
                    end
                end
                ST_SETTLE: begin
                    state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    key_vld_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aria_key_load_ctrl.sv
// Directed bench for aria_key_load_ctrl with hand-computed expectations.
module tb_aria_key_load_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr_core;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [1:0]   cmd_op;
    logic         cmd_abort;
    logic         wr_vld;
    logic         wr_rdy;
    logic [31:0]  wr_data;
    logic [1:0]   kb_op;
    logic         kb_en;
    logic         kb_clr;
    logic [127:0] wb_d;
    logic         kb_d_vld;
    logic         kb_d_rdy;
    logic         busy;
    logic         key_vld;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic seen_clr;

    aria_key_load_ctrl #(.KB_TO(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_core  (clr_core),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_op    (cmd_op),
        .cmd_abort (cmd_abort),
        .wr_vld    (wr_vld),
        .wr_rdy    (wr_rdy),
        .wr_data   (wr_data),
        .kb_op     (kb_op),
        .kb_en     (kb_en),
        .kb_clr    (kb_clr),
        .wb_d      (wb_d),
        .kb_d_vld  (kb_d_vld),
        .kb_d_rdy  (kb_d_rdy),
        .busy      (busy),
        .key_vld   (key_vld),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        wr_vld  = 1'b1;
        wr_data = w;
        tick();
        wr_vld  = 1'b0;
    endtask

    task automatic start_cmd(input logic [1:0] op);
        cmd_vld = 1'b1;
        cmd_op  = op;
        tick();
        cmd_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr_core = 1'b0; cmd_vld = 1'b0; cmd_op = 2'd0;
        cmd_abort = 1'b0; wr_vld = 1'b0; wr_data = '0; kb_d_rdy = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_cmd_rdy", cmd_rdy, 1); chk("rst_busy", busy, 0);
        chk("rst_kb_en", kb_en, 0);     chk("rst_kb_clr", kb_clr, 0);
        chk("rst_kb_d_vld", kb_d_vld, 0); chk("rst_wb_d", wb_d, 0);
        chk("rst_key_vld", key_vld, 0); chk("rst_err", err, 0);
        chk("rst_kb_op", kb_op, 0);     chk("rst_wr_rdy", wr_rdy, 0);
        rst_n = 1'b1;
        tick();

        // op 0, single beat, kb_d_rdy high
        kb_d_rdy = 1'b1;
        start_cmd(2'd0);
        chk("t1_issue_kb_en", kb_en, 1); chk("t1_issue_busy", busy, 1);
        chk("t1_issue_cmd_rdy", cmd_rdy, 0); chk("t1_issue_wr_rdy", wr_rdy, 0);
        tick();
        chk("t1_fill_wr_rdy", wr_rdy, 1); chk("t1_fill_kb_en", kb_en, 0);
        send_word(32'h00010203); send_word(32'h04050607);
        send_word(32'h08090A0B); send_word(32'h0C0D0E0F);
        chk("t1_push_vld", kb_d_vld, 1); chk("t1_push_wr_rdy", wr_rdy, 0);
        chk("t1_push_wb_d", wb_d, 128'h000102030405060708090A0B0C0D0E0F);
        tick();
        chk("t1_done_vld", kb_d_vld, 0); chk("t1_done_key_vld", key_vld, 0);
        chk("t1_done_busy", busy, 1);
        tick();
        chk("t1_key_vld", key_vld, 1); chk("t1_idle_busy", busy, 0);
        chk("t1_err", err, 0);

        // op 1, two beats with 3-cycle stalls each
        kb_d_rdy = 1'b0;
        start_cmd(2'd1);
        chk("t2_kb_op", kb_op, 1); chk("t2_key_vld_clr", key_vld, 0);
        tick();
        send_word(32'h10111213); send_word(32'h14151617);
        send_word(32'h18191A1B); send_word(32'h1C1D1E1F);
        for (int i = 0; i < 3; i++) begin
            chk("t2_b0_stall_vld", kb_d_vld, 1);
            chk("t2_b0_stall_wb_d", wb_d, 128'h101112131415161718191A1B1C1D1E1F);
            tick();
        end
        kb_d_rdy = 1'b1;
        chk("t2_b0_xfer_wb_d", wb_d, 128'h101112131415161718191A1B1C1D1E1F);
        tick();
        kb_d_rdy = 1'b0;
        chk("t2_refill_wr_rdy", wr_rdy, 1); chk("t2_refill_vld", kb_d_vld, 0);
        send_word(32'h20212223); send_word(32'h24252627);
        send_word(32'h28292A2B); send_word(32'h2C2D2E2F);
        for (int i = 0; i < 3; i++) begin
            chk("t2_b1_stall_vld", kb_d_vld, 1);
            chk("t2_b1_stall_wb_d", wb_d, 128'h202122232425262728292A2B2C2D2E2F);
            tick();
        end
        kb_d_rdy = 1'b1;
        tick();
        chk("t2_done_vld", kb_d_vld, 0); chk("t2_done_busy", busy, 1);
        tick();
        chk("t2_key_vld", key_vld, 1); chk("t2_err", err, 0);

        // op 2 (SW key): no words, no beat
        start_cmd(2'd2);
        chk("t3_kb_en", kb_en, 1); chk("t3_kb_op", kb_op, 2);
        chk("t3_key_vld_clr", key_vld, 0);
        tick();
        chk("t3_settle_kb_en", kb_en, 0); chk("t3_settle_vld", kb_d_vld, 0);
        chk("t3_settle_wr_rdy", wr_rdy, 0); chk("t3_settle_busy", busy, 1);
        tick();
        chk("t3_done_key_vld", key_vld, 0); chk("t3_done_wr_rdy", wr_rdy, 0);
        tick();
        chk("t3_key_vld", key_vld, 1); chk("t3_idle_busy", busy, 0);

        // op 0 with kb_d_rdy held low: timeout 16 cycles after PUSH entry
        kb_d_rdy = 1'b0;
        start_cmd(2'd0);
        tick();
        send_word(32'h11111111); send_word(32'h22222222);
        send_word(32'h33333333); send_word(32'h44444444);
        chk("t4_push_vld", kb_d_vld, 1);
        seen_clr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_clr = seen_clr | kb_clr | err;
        end
        chk("t4_no_early_to", seen_clr, 0); chk("t4_still_push", kb_d_vld, 1);
        tick();
        chk("t4_err", err, 1); chk("t4_kb_clr", kb_clr, 1);
        chk("t4_idle", cmd_rdy, 1); chk("t4_key_vld", key_vld, 0);
        chk("t4_vld_off", kb_d_vld, 0);
        tick();
        chk("t4_kb_clr_pulse", kb_clr, 0); chk("t4_err_hold", err, 1);

        // cmd_abort after two words of op 1, then a clean op 0
        start_cmd(2'd1);
        chk("t5_err_clr", err, 0);
        tick();
        send_word(32'hDEADBEEF); send_word(32'hCAFEF00D);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("t5_kb_clr", kb_clr, 1); chk("t5_key_vld", key_vld, 0);
        chk("t5_idle", cmd_rdy, 1); chk("t5_err", err, 0);
        tick();
        chk("t5_kb_clr_pulse", kb_clr, 0);
        kb_d_rdy = 1'b1;
        start_cmd(2'd0);
        tick();
        send_word(32'hA0A1A2A3); send_word(32'hA4A5A6A7);
        send_word(32'hA8A9AAAB); send_word(32'hACADAEAF);
        chk("t5_wb_d", wb_d, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        chk("t5_push_vld", kb_d_vld, 1);
        tick(); tick();
        chk("t5_key_vld_done", key_vld, 1);

        // cmd_abort ignored in IDLE
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("t6_idle_abort_clr", kb_clr, 0); chk("t6_idle_abort_kv", key_vld, 1);

        // clr_core together with cmd_abort during PUSH
        kb_d_rdy = 1'b0;
        start_cmd(2'd0);
        tick();
        send_word(32'h55555555); send_word(32'h66666666);
        send_word(32'h77777777); send_word(32'h88888888);
        chk("t7_push_vld", kb_d_vld, 1);
        clr_core = 1'b1; cmd_abort = 1'b1;
        tick();
        clr_core = 1'b0; cmd_abort = 1'b0;
        chk("t7_idle", cmd_rdy, 1); chk("t7_no_kb_clr", kb_clr, 0);
        chk("t7_err", err, 0); chk("t7_wb_d", wb_d, 0);
        chk("t7_busy", busy, 0); chk("t7_vld", kb_d_vld, 0);
        tick();
        chk("t7_no_kb_clr_later", kb_clr, 0);

        // Async reset in the middle of a load
        start_cmd(2'd0);
        tick();
        send_word(32'h99999999); send_word(32'hAAAAAAAA);
        rst_n = 1'b0;
        #1;
        chk("t8_idle", cmd_rdy, 1); chk("t8_kb_clr", kb_clr, 0);
        chk("t8_wb_d", wb_d, 0); chk("t8_wr_rdy", wr_rdy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t8_no_kb_clr_after", kb_clr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aria_key_load_ctrl.md
ARIA_KEY_LOAD_CTRL -- requirements
Module: aria_key_load_ctrl

Interface
REQ-001 Parameter: KB_TO, default 16, max cycles PUSH waits for kb_d_rdy before timeout (range 2..255).
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 clr_core  in  1  synchronous core clear.
REQ-005 cmd_vld / cmd_rdy  in/out  1/1  key-load command handshake.
REQ-006 cmd_op  in  2  0=128-bit, 1=256-bit, 2=SW key, 3=CW key.
REQ-007 cmd_abort  in  1  abort in-flight load.
REQ-008 wr_vld / wr_rdy  in/out  1/1  host key-word handshake.
REQ-009 wr_data  in  32  host key word.
REQ-010 kb_op  out  2  key-buffer operation.
REQ-011 kb_en  out  1  key-buffer start pulse.
REQ-012 kb_clr  out  1  key-buffer clear pulse.
REQ-013 wb_d  out  128  key beat to key buffer.
REQ-014 kb_d_vld / kb_d_rdy  out/in  1/1  key-beat handshake.
REQ-015 busy, key_vld, err  out  1 each  status.

Function
REQ-016 FSM states: IDLE, ISSUE, FILL, PUSH, SETTLE, DONE; one-hot encoding.
REQ-017 IDLE: cmd_rdy=1; on cmd_vld latch cmd_op into kb_op, clear key_vld and err, go ISSUE.
REQ-018 ISSUE (1 cycle): kb_en=1; next FILL for op 0/1, SETTLE for op 2/3.
REQ-019 FILL: wr_rdy=1; each wr_vld&wr_rdy shifts wr_data into a 128-bit assembly register, first word landing at [127:96], fourth at [31:0]; 2-bit word counter.
REQ-020 After the fourth accepted word go PUSH; wr_rdy=0 outside FILL.
REQ-021 PUSH: kb_d_vld=1, wb_d=assembly register, held stable until kb_d_rdy=1; the beat transfers on kb_d_vld&kb_d_rdy.
REQ-022 On transfer: op 1 and beat 0 -> FILL (beat index=1, counter=0); otherwise -> DONE.
REQ-023 SETTLE (1 cycle): no outputs asserted, covers the key buffer's single-cycle SW/CW load; next DONE.
REQ-024 DONE (1 cycle): key_vld<=1, go IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 Timeout: counter cleared on PUSH entry, increments each PUSH cycle without kb_d_rdy; at KB_TO: err<=1, kb_clr pulse 1 cycle, key_vld<=0, go IDLE.
REQ-027 cmd_abort in any non-IDLE state: kb_clr pulse 1 cycle, key_vld<=0, counters cleared, go IDLE; err unchanged; ignored in IDLE.
REQ-028 clr_core: same-cycle clear of FSM to IDLE, counters, assembly register, key_vld, err; no kb_clr pulse (key buffer sees clr_core).
REQ-029 Priority: clr_core > cmd_abort > timeout > normal transition.
REQ-030 cmd_vld outside IDLE is not accepted (cmd_rdy=0); wr_vld outside FILL is not accepted.
REQ-031 kb_en, kb_clr, kb_d_vld never asserted in the same cycle.
REQ-032 wb_d driven from register only; no combinational path wr_data -> wb_d.

Reset
REQ-033 On rst_n low: state=IDLE; kb_op=0; kb_en=kb_clr=kb_d_vld=0; wb_d=0; key_vld=err=0; counters=0.
REQ-034 Reset mid-load abandons the load with no kb_clr pulse.

Structure
REQ-035 Shared package aria_pkg: cmd_op/kb_op encodings (KOP_128, KOP_256, KOP_SW, KOP_CW) and FSM state encodings.
REQ-036 One sub-module natural: aria_key_word_pack (32->128 assembler with word counter and full flag).
REQ-037 Estimated RTL size 150-250 lines.

Verification
REQ-038 op 0, words 0x00010203,0x04050607,0x08090A0B,0x0C0D0E0F, kb_d_rdy=1 -> kb_en at ISSUE, wb_d=0x000102030405060708090A0B0C0D0E0F, key_vld=1 two cycles after transfer.
REQ-039 op 1, 8 words, kb_d_rdy stalled 3 cycles per beat -> two beats in order, wb_d stable during stalls, key_vld=1.
REQ-040 op 2 -> kb_en pulse with kb_op=2, no kb_d_vld, key_vld=1 after 3 cycles; no wr_rdy.
REQ-041 op 0, kb_d_rdy held 0, KB_TO=16 -> err=1 and one kb_clr pulse 16 cycles after PUSH entry, IDLE.
REQ-042 cmd_abort after 2 words of op 1 -> kb_clr pulse, key_vld=0, next op 0 load completes correctly.
REQ-043 clr_core asserted together with cmd_abort during PUSH -> IDLE, no kb_clr pulse, err=0.
